// File: rtl/rom_reader.sv
// rom_reader: reads `count` consecutive words from a synchronous ROM and streams them on a valid/ready output.
// Latency: first word valid ROM_LATENCY+1 cycles after the start edge; one word per ROM_LATENCY+2 cycles.
// Backpressure: out_data/out_valid hold while out_ready is low and the ROM address does not advance.
// Optional: define ROM_READER_CHECKSUM_EN to add a running XOR checksum of the handshaked words.
module rom_reader #(
    parameter  int WIDTH       = 8,
    parameter  int DEPTH       = 16,
    parameter  int ROM_LATENCY = 1,
    localparam int LOG_DEPTH   = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [LOG_DEPTH-1:0] start_addr,
    input  logic [LOG_DEPTH:0]   count,
    output logic                 busy,
    output logic                 done,
    output logic [LOG_DEPTH-1:0] rom_addr,
    input  logic [WIDTH-1:0]     rom_data,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready
`ifdef ROM_READER_CHECKSUM_EN
    ,
    output logic [WIDTH-1:0]     checksum
`endif
);

    localparam int WAIT_W = $clog2(ROM_LATENCY + 1) + 1;

    localparam logic [LOG_DEPTH:0]   MAX_COUNT = (LOG_DEPTH + 1)'(DEPTH);
    localparam logic [LOG_DEPTH:0]   ONE_WORD  = (LOG_DEPTH + 1)'(1);
    localparam logic [LOG_DEPTH-1:0] LAST_ADDR = LOG_DEPTH'(DEPTH - 1);
    localparam logic [WAIT_W-1:0]    WAIT_LAST = WAIT_W'(ROM_LATENCY);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        PRESENT,
        DONE
    } state_t;

    state_t               state;
    logic [LOG_DEPTH:0]   remaining;
    logic [WAIT_W-1:0]    wait_cnt;
    logic [LOG_DEPTH:0]   count_clamped;
    logic [LOG_DEPTH-1:0] next_addr;
    logic                 handshake;

    // Requests larger than the ROM read every word once rather than re-reading.
    assign count_clamped = (count > MAX_COUNT) ? MAX_COUNT : count;
    // Address advances modulo DEPTH, which also covers non-power-of-two ROMs.
    assign next_addr     = (rom_addr == LAST_ADDR) ? '0 : rom_addr + 1'b1;
    assign handshake     = (state == PRESENT) && out_ready;

    // Burst sequencer: issue address, wait out the ROM latency, present the word, repeat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            rom_addr  <= '0;
            remaining <= '0;
            wait_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        busy      <= 1'b1;
                        wait_cnt  <= '0;
                        remaining <= count_clamped;
                        if (count_clamped == '0) begin
                            state <= DONE;
                        end else begin
                            rom_addr <= start_addr;
                            state    <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    // The ROM output reflects rom_addr once WAIT_LAST edges have passed.
                    if (wait_cnt == WAIT_LAST) begin
                        out_data  <= rom_data;
                        out_valid <= 1'b1;
                        state     <= PRESENT;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                PRESENT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        remaining <= remaining - 1'b1;
                        if (remaining > ONE_WORD) begin
                            rom_addr <= next_addr;
                            wait_cnt <= '0;
                            state    <= FETCH;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    // done and the falling busy share the same cycle.
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef ROM_READER_CHECKSUM_EN
    // Running XOR of accepted words; holds its final value until the next accepted start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            checksum <= '0;
        end else if ((state == IDLE) && start) begin
            checksum <= '0;
        end else if (handshake) begin
            checksum <= checksum ^ out_data;
        end
    end
`endif

endmodule
